timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 31 +++
 rtl/timer_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller.
package timer_pkg;

    // Controller states; the encoding is what appears on state_o.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EDIT    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_EXPIRED = 3'd5
    } state_t;

    // Which preset field the edit cursor is on.
    localparam logic [1:0] FIELD_NONE  = 2'd0;
    localparam logic [1:0] FIELD_HOURS = 2'd1;
    localparam logic [1:0] FIELD_MINS  = 2'd2;
    localparam logic [1:0] FIELD_SECS  = 2'd3;

    localparam int HOURS_MAX  = 23;
    localparam int MINSEC_MAX = 59;

    // Hours increment with wrap 23 -> 0.
    function automatic logic [4:0] next_hours(input logic [4:0] val);
        return (val >= 5'(HOURS_MAX)) ? 5'd0 : val + 5'd1;
    endfunction

    // Minutes/seconds increment with wrap 59 -> 0.
    function automatic logic [5:0] next_minsec(input logic [5:0] val);
        return (val >= 6'(MINSEC_MAX)) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled, holds when idle,
// and flags the last count of each period with a wrap pulse.
module tick_prescaler #(
    parameter int DIV = 100000000,
    parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    logic [W-1:0] count;
    logic         last;

    assign last = (count == W'(DIV - 1));
    assign wrap = enable & last;

    // Clear has priority over counting; with neither, the phase is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: preset editing, start/pause/resume, 1 Hz tick
// generation and the expiry alarm. The countdown itself lives outside and
// reports back through cnt_zero.
//
// Interface contract: the four buttons are debounced single-cycle strobes,
// sampled on every rising edge with no backpressure; when several arrive in
// one cycle only the highest priority one acts (clear > start > mode > inc).
// load and tick_en are single-cycle strobes to the datapath, which must
// accept them in the cycle they are high.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clear,
    input  logic       cnt_zero,
    output logic       load,
    output logic       tick_en,
    output logic [4:0] hours_set,
    output logic [5:0] mins_set,
    output logic [5:0] secs_set,
    output logic [1:0] edit_field,
    output logic [2:0] state_o,
    output logic       alarm
);

    localparam int AW = $clog2(ALARM_SECS + 1);

    state_t        state, state_nx;
    logic [1:0]    field_nx;
    logic [4:0]    hours_nx;
    logic [5:0]    mins_nx, secs_nx;
    logic [AW-1:0] alarm_cnt, alarm_cnt_nx, alarm_cnt_inc;

    logic do_clear, do_start, do_mode, do_inc, any_btn;
    logic preset_nz;
    logic pre_clear, pre_enable, pre_wrap;

    // Button priority resolution: a lower button is masked by any higher one.
    assign do_clear = btn_clear;
    assign do_start = btn_start & ~btn_clear;
    assign do_mode  = btn_mode & ~btn_start & ~btn_clear;
    assign do_inc   = btn_inc & ~btn_mode & ~btn_start & ~btn_clear;
    assign any_btn  = btn_clear | btn_start | btn_mode | btn_inc;

    assign preset_nz     = (hours_set != '0) || (mins_set != '0) || (secs_set != '0);
    assign alarm_cnt_inc = alarm_cnt + AW'(1);

    // Prescaler is parked at zero outside a countdown, held in PAUSE so a
    // resume keeps the sub-second phase, and restarted by LOAD.
    assign pre_clear  = (state == ST_IDLE) || (state == ST_EDIT) || (state == ST_LOAD);
    assign pre_enable = (state == ST_RUN) || (state == ST_EXPIRED);

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_enable),
        .wrap   (pre_wrap)
    );

    assign state_o = state;

    // Next-state, preset and alarm-counter decisions.
    always_comb begin
        state_nx     = state;
        field_nx     = edit_field;
        hours_nx     = hours_set;
        mins_nx      = mins_set;
        secs_nx      = secs_set;
        alarm_cnt_nx = '0;
        case (state)
            ST_IDLE: begin
                if (do_start) begin
                    if (preset_nz) state_nx = ST_LOAD;
                end else if (do_mode) begin
                    state_nx = ST_EDIT;
                    field_nx = FIELD_HOURS;
                end
            end
            ST_EDIT: begin
                if (do_clear) begin
                    hours_nx = '0;
                    mins_nx  = '0;
                    secs_nx  = '0;
                end else if (do_start) begin
                    if (preset_nz) begin
                        state_nx = ST_LOAD;
                        field_nx = FIELD_NONE;
                    end
                end else if (do_mode) begin
                    case (edit_field)
                        FIELD_HOURS: field_nx = FIELD_MINS;
                        FIELD_MINS:  field_nx = FIELD_SECS;
                        default: begin
                            state_nx = ST_IDLE;
                            field_nx = FIELD_NONE;
                        end
                    endcase
                end else if (do_inc) begin
                    case (edit_field)
                        FIELD_HOURS: hours_nx = next_hours(hours_set);
                        FIELD_MINS:  mins_nx  = next_minsec(mins_set);
                        FIELD_SECS:  secs_nx  = next_minsec(secs_set);
                        default:     ;
                    endcase
                end
            end
            ST_LOAD: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                // Expiry outranks pause so a finished count is never parked.
                if (do_clear)       state_nx = ST_IDLE;
                else if (cnt_zero)  state_nx = ST_EXPIRED;
                else if (do_start)  state_nx = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (do_clear)       state_nx = ST_IDLE;
                else if (do_start)  state_nx = ST_RUN;
            end
            ST_EXPIRED: begin
                alarm_cnt_nx = alarm_cnt;
                if (any_btn) begin
                    state_nx     = ST_IDLE;
                    alarm_cnt_nx = '0;
                end else if (pre_wrap) begin
                    if (alarm_cnt_inc == AW'(ALARM_SECS)) begin
                        state_nx     = ST_IDLE;
                        alarm_cnt_nx = '0;
                    end else begin
                        alarm_cnt_nx = alarm_cnt_inc;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                field_nx = FIELD_NONE;
            end
        endcase
    end

    // State, presets and registered strobes. tick_en is issued the cycle
    // after a prescaler wrap, and only if the controller stays in RUN, so a
    // pause, abort or expiry in the wrap cycle swallows that tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            edit_field <= FIELD_NONE;
            hours_set  <= '0;
            mins_set   <= '0;
            secs_set   <= '0;
            alarm_cnt  <= '0;
            load       <= 1'b0;
            tick_en    <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_nx;
            edit_field <= field_nx;
            hours_set  <= hours_nx;
            mins_set   <= mins_nx;
            secs_set   <= secs_nx;
            alarm_cnt  <= alarm_cnt_nx;
            load       <= (state_nx == ST_LOAD);
            tick_en    <= (state == ST_RUN) && pre_wrap && (state_nx == ST_RUN);
            alarm      <= (state_nx == ST_EXPIRED);
        end
    end

endmodule
